// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: read-side bus between the receive FIFO and the UART regs.
// master = register block (drives rd_en); slave = FIFO (head, valid, count).
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                        rd_en;
    logic [7:0]                  rd_data;
    logic                        rd_valid;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    modport master (
        output rd_en,
        input  rd_data,
        input  rd_valid,
        input  fifo_count
    );

    modport slave (
        input  rd_en,
        output rd_data,
        output rd_valid,
        output fifo_count
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver with show-ahead byte FIFO and sticky errors.
// Ports: clk, rst_n (sync, active-low), rx pin, divisor (clocks/bit), bus
// (slave: rd_en in; rd_data/rd_valid/fifo_count out), frame_err, overrun_err,
// err_clr. Define UART_RX_PARITY_EN for an even-parity bit and parity_err.
module uart_rx_fifo #(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] divisor,
    uart_rx_fifo_if.slave        bus,
    output logic                 frame_err,
    output logic                 overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    input  logic                 err_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state, state_n;
    logic [1:0]           sync;
    logic                 rxs, rxs_d;
    logic [DIV_WIDTH-1:0] cnt, cnt_n;
    logic [DIV_WIDTH-1:0] div_q, div_n;
    logic [7:0]           shreg, sh_n;
    logic [2:0]           bit_idx, bit_n;
    logic                 tick;
    logic                 push, frame_set;
`ifdef UART_RX_PARITY_EN
    logic                 par_ok, par_ok_n, parity_set;
`endif

    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 full, pop, do_push, ovr_set;

    assign rxs  = sync[1];
    // Counter expiry: the sample point is the cycle the counter reads 1.
    assign tick = (cnt == DIV_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            rxs_d   <= 1'b1;
            state   <= S_IDLE;
            cnt     <= '0;
            div_q   <= '0;
            shreg   <= '0;
            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
            par_ok  <= 1'b1;
`endif
        end else begin
            sync    <= {sync[0], rx};
            rxs_d   <= rxs;
            state   <= state_n;
            cnt     <= cnt_n;
            div_q   <= div_n;
            shreg   <= sh_n;
            bit_idx <= bit_n;
`ifdef UART_RX_PARITY_EN
            par_ok  <= par_ok_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        div_n      = div_q;
        sh_n       = shreg;
        bit_n      = bit_idx;
        push       = 1'b0;
        frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_ok_n   = par_ok;
        parity_set = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                // Divisor is captured here so mid-frame changes are ignored.
                if (rxs_d && !rxs) begin
                    div_n   = divisor;
                    cnt_n   = divisor >> 1;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (!tick) begin
                    cnt_n = cnt - DIV_WIDTH'(1);
                end else if (rxs) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n   = div_q;
                    bit_n   = 3'd0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    cnt_n = cnt - DIV_WIDTH'(1);
                end else begin
                    sh_n  = {rxs, shreg[7:1]};
                    cnt_n = div_q;
                    bit_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!tick) begin
                    cnt_n = cnt - DIV_WIDTH'(1);
                end else begin
                    par_ok_n   = (rxs == ^shreg);
                    parity_set = (rxs != ^shreg);
                    cnt_n      = div_q;
                    state_n    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (!tick) begin
                    cnt_n = cnt - DIV_WIDTH'(1);
                end else begin
                    // Back to IDLE mid stop bit so the next start edge is seen.
`ifdef UART_RX_PARITY_EN
                    push      = rxs && par_ok;
`else
                    push      = rxs;
`endif
                    frame_set = !rxs;
                    state_n   = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = bus.rd_en && (count != '0);
    // A pop in the same cycle frees the slot for a push into a full FIFO.
    assign do_push = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.rd_valid   = (count != '0);
    assign bus.rd_data    = (count != '0) ? mem[rd_ptr] : 8'h00;
    assign bus.fifo_count = count;

    // Sticky flags: a new error event wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            if (frame_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (ovr_set) begin
                overrun_err <= 1'b1;
            end else if (err_clr) begin
                overrun_err <= 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            if (parity_set) begin
                parity_err <= 1'b1;
            end else if (err_clr) begin
                parity_err <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized frames against a queue model.
// Frames are driven on the pin; expectations come from the model only.
module tb_uart_rx_fifo;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          rx      = 1'b1;
    logic          err_clr = 1'b0;
    logic [DW-1:0] divisor = 16'd10;
    logic          frame_err, overrun_err;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .DIV_WIDTH (DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .divisor    (divisor),
        .bus        (bus.slave),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] q[$];
    bit         frame_m, ovr_m, par_m;
    logic       rv_at_push, rv_after_push;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(bus.fifo_count), q.size());
        check({tag, ".valid"}, 32'(bus.rd_valid), 32'(q.size() != 0));
        check({tag, ".data"}, 32'(bus.rd_data),
              (q.size() != 0) ? 32'(q[0]) : 32'h0);
        check({tag, ".ferr"}, 32'(frame_err), 32'(frame_m));
        check({tag, ".oerr"}, 32'(overrun_err), 32'(ovr_m));
`ifdef UART_RX_PARITY_EN
        check({tag, ".perr"}, 32'(parity_err), 32'(par_m));
`endif
    endtask

    // One frame on the pin. The push lands on the stop-sample cycle, which
    // is pin-start + 2 (synchroniser) + floor(d/2) + (NB-1)*d.
    task automatic send_frame(input logic [7:0] b, input int d,
                              input bit stop_bit, input bit par_flip,
                              input bit pop_at, input bit clr_at,
                              input bit scramble);
        logic [NB-1:0] bits;
        int push_c;
        int len;
        bits[0]      = 1'b0;
        bits[8:1]    = b;
`ifdef UART_RX_PARITY_EN
        bits[9]      = (^b) ^ par_flip;
`endif
        bits[NB-1]   = stop_bit;
        push_c       = 2 + d / 2 + (NB - 1) * d;
        len          = (NB * d > push_c + 2) ? NB * d : push_c + 2;
        divisor      = DW'(d);
        for (int c = 0; c < len; c++) begin
            rx          = (c < NB * d) ? bits[c / d] : 1'b1;
            bus.rd_en   = pop_at && (c == push_c);
            err_clr     = clr_at && (c == push_c);
            if (scramble && c == 3 * d) divisor = DW'($urandom_range(4, 40));
            if (c == push_c) rv_at_push = bus.rd_valid;
            if (c == push_c + 1) rv_after_push = bus.rd_valid;
            @(posedge clk);
            #1;
        end
        rx        = 1'b1;
        bus.rd_en = 1'b0;
        err_clr   = 1'b0;
        if (clr_at) begin
            frame_m = 1'b0;
            ovr_m   = 1'b0;
            par_m   = 1'b0;
        end
        if (pop_at && q.size() != 0) void'(q.pop_front());
        if (!stop_bit) frame_m = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (par_flip) par_m = 1'b1;
`endif
        if (stop_bit && !par_flip) begin
            if (q.size() == DEPTH) ovr_m = 1'b1;
            else q.push_back(b);
        end
    endtask

    task automatic read_one(input string tag);
        if (q.size() != 0) begin
            check({tag, ".head"}, 32'(bus.rd_data), 32'(q[0]));
            void'(q.pop_front());
        end
        bus.rd_en = 1'b1;
        cyc(1);
        bus.rd_en = 1'b0;
        check({tag, ".cnt"}, 32'(bus.fifo_count), q.size());
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        frame_m = 1'b0;
        ovr_m   = 1'b0;
        par_m   = 1'b0;
    endtask

    initial begin
        bus.rd_en = 1'b0;
        frame_m   = 1'b0;
        ovr_m     = 1'b0;
        par_m     = 1'b0;

        // Reset state
        cyc(3);
        check_state("rst_hold");
        rst_n = 1'b1;
        cyc(3);
        check_state("rst_rel");

        // D=10, 0xA5: valid appears exactly one cycle after the push cycle
        send_frame(8'hA5, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("a5.rv_push", 32'(rv_at_push), 32'h0);
        check("a5.rv_next", 32'(rv_after_push), 32'h1);
        check_state("a5");
        read_one("a5.rd");
        check_state("a5.empty");

        // False start: 3-cycle low glitch
        divisor = 16'd10;
        rx = 1'b0;
        cyc(3);
        rx = 1'b1;
        cyc(30);
        check_state("glitch");

        // Framing error, then clear; then clear coincident with a new error
        send_frame(8'h3C, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(4);
        check_state("ferr");
        clear_errs();
        check_state("ferr.clr");
        send_frame(8'h3C, 10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(4);
        check_state("ferr.setwins");
        clear_errs();

        // D=8 back-to-back, overrun on 5th byte
        for (int i = 1; i <= 5; i++)
            send_frame(8'(i), 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("ovr");
        for (int i = 0; i < 4; i++) read_one("ovr.rd");
        check_state("ovr.drained");
        clear_errs();

        // Same, but a pop coincides with the 5th push
        for (int i = 1; i <= 5; i++)
            send_frame(8'(i), 8, 1'b1, 1'b0, (i == 5), 1'b0, 1'b0);
        check_state("popush");
        for (int i = 0; i < 4; i++) read_one("popush.rd");

        // Reset in the middle of bit 4 abandons the frame and empties FIFO
        send_frame(8'h11, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        divisor = 16'd16;
        rx = 1'b0;
        cyc(16 + 64 + 8);
        rst_n = 1'b0;
        rx    = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        q.delete();
        frame_m = 1'b0;
        ovr_m   = 1'b0;
        par_m   = 1'b0;
        cyc(5);
        check_state("midrst");
        send_frame(8'h5A, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("midrst.5a");
        read_one("midrst.rd");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("par.ok");
        send_frame(8'h07, 10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_state("par.bad");
        read_one("par.rd");
        clear_errs();
`endif

        // Randomized frames, divisors, stop errors, reads and clears
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int d;
            bit sb, pf;
            b  = 8'($urandom);
            d  = $urandom_range(4, 20);
            sb = ($urandom_range(0, 6) != 0);
            pf = 1'b0;
`ifdef UART_RX_PARITY_EN
            pf = ($urandom_range(0, 9) == 0);
`endif
            send_frame(b, d, sb, pf, 1'b0, 1'b0, $urandom_range(0, 1) == 1);
            cyc(sb ? $urandom_range(0, 3) : 3 + $urandom_range(0, 3));
            check_state("rnd");
            repeat ($urandom_range(0, 2)) read_one("rnd.rd");
            if ($urandom_range(0, 4) == 0) clear_errs();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
